// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and index type
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - write-back and decode read bus of the register file
// Debug read port present only when REGFILE_DEBUG_EN is defined.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) ();

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
`ifdef REGFILE_DEBUG_EN
    logic [ADDR_W-1:0] dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
`endif

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
`ifdef REGFILE_DEBUG_EN
        output dbg_raddr,
        input  dbg_rdata,
`endif
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
`ifdef REGFILE_DEBUG_EN
        input  dbg_raddr,
        output dbg_rdata,
`endif
        output rdata1, rdata2
    );

endinterface

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - combinational read port with optional write bypass
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W    = REG_DATA_W,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] array_data,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = '0;
        if (rst || !en || raddr == ADDR_W'(REG_ZERO)) begin
            rdata = '0;
        end else if (BYPASS_EN && we && waddr == raddr) begin
            rdata = wdata;
        end else begin
            rdata = array_data;
        end
    end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 2-read/1-write register file, r0 hard-wired to zero
// Optional REGFILE_DEBUG_EN adds a non-bypassing debug read port.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NREG   = 2 ** ADDR_W
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    logic [DATA_W-1:0] mem [NREG];

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.we && bus.waddr != ADDR_W'(REG_ZERO)) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    regfile_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (1'b1)
    ) u_rp1 (
        .rst        (rst),
        .en         (bus.re1),
        .raddr      (bus.raddr1),
        .we         (bus.we),
        .waddr      (bus.waddr),
        .wdata      (bus.wdata),
        .array_data (mem[bus.raddr1]),
        .rdata      (bus.rdata1)
    );

    regfile_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (1'b1)
    ) u_rp2 (
        .rst        (rst),
        .en         (bus.re2),
        .raddr      (bus.raddr2),
        .we         (bus.we),
        .waddr      (bus.waddr),
        .wdata      (bus.wdata),
        .array_data (mem[bus.raddr2]),
        .rdata      (bus.rdata2)
    );

`ifdef REGFILE_DEBUG_EN
    // Trace view shows committed state only, hence no bypass.
    regfile_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (1'b0)
    ) u_rp_dbg (
        .rst        (rst),
        .en         (1'b1),
        .raddr      (bus.dbg_raddr),
        .we         (bus.we),
        .waddr      (bus.waddr),
        .wdata      (bus.wdata),
        .array_data (mem[bus.dbg_raddr]),
        .rdata      (bus.dbg_rdata)
    );
`endif

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench for regfile
module tb_regfile;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change 1ns after a rising edge and are sampled 2ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst        = 1'b1;
        bus.we     = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.re1    = 1'b0;
        bus.raddr1 = '0;
        bus.re2    = 1'b0;
        bus.raddr2 = '0;
`ifdef REGFILE_DEBUG_EN
        bus.dbg_raddr = '0;
`endif
        next_cycle();

        // Preload reg5, then reset and confirm it clears.
        rst = 1'b0;
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
        next_cycle();
        bus.we = 1'b0; bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        settle();
        chk("preload_r5", bus.rdata1, 32'hDEADBEEF);

        rst = 1'b1;
        bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h00000001;
        bus.re2 = 1'b1; bus.raddr2 = 5'd5;
        settle();
        chk("rst_force_rd1", bus.rdata1, 32'h0);
        chk("rst_force_rd2", bus.rdata2, 32'h0);
        next_cycle();
        rst = 1'b0; bus.we = 1'b0; bus.re2 = 1'b0;
        settle();
        chk("rst_clear_r5", bus.rdata1, 32'h0);

        // Basic write then read, and disabled read port.
        bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'h12345678;
        bus.re1 = 1'b0; bus.raddr1 = 5'd3;
        settle();
        chk("re1_off_bypass", bus.rdata1, 32'h0);
        next_cycle();
        bus.we = 1'b0; bus.re1 = 1'b1;
        settle();
        chk("read_r3", bus.rdata1, 32'h12345678);
        bus.re1 = 1'b0;
        settle();
        chk("read_r3_re_off", bus.rdata1, 32'h0);

        // Register 0 ignores writes and never bypasses.
        bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
        bus.re1 = 1'b1; bus.raddr1 = 5'd0; bus.re2 = 1'b1; bus.raddr2 = 5'd0;
        settle();
        chk("r0_same_cyc_rd1", bus.rdata1, 32'h0);
        chk("r0_same_cyc_rd2", bus.rdata2, 32'h0);
        next_cycle();
        bus.we = 1'b0;
        settle();
        chk("r0_after_rd1", bus.rdata1, 32'h0);
        chk("r0_after_rd2", bus.rdata2, 32'h0);

        // Bypass on both ports over an older value.
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h00000001;
        next_cycle();
        bus.we = 1'b0; bus.raddr1 = 5'd7; bus.raddr2 = 5'd3;
        settle();
        chk("r7_old", bus.rdata1, 32'h00000001);
        chk("r3_port2", bus.rdata2, 32'h12345678);
        bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h0000ABCD;
        settle();
        chk("bypass_other_idx", bus.rdata2, 32'h12345678);
        bus.raddr2 = 5'd7;
        settle();
        chk("bypass_rd1", bus.rdata1, 32'h0000ABCD);
        chk("bypass_rd2", bus.rdata2, 32'h0000ABCD);
        next_cycle();
        bus.we = 1'b0;
        settle();
        chk("r7_commit_rd1", bus.rdata1, 32'h0000ABCD);
        chk("r7_commit_rd2", bus.rdata2, 32'h0000ABCD);

        // Write during reset is dropped; first write after reset lands.
        rst = 1'b1;
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h00000055;
        next_cycle();
        rst = 1'b0; bus.we = 1'b0; bus.raddr1 = 5'd9; bus.raddr2 = 5'd7;
        settle();
        chk("rst_write_lost", bus.rdata1, 32'h0);
        chk("rst_clear_r7", bus.rdata2, 32'h0);
        bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h00000055;
        next_cycle();
        bus.we = 1'b0;
        settle();
        chk("first_write_after_rst", bus.rdata1, 32'h00000055);

        // Top index boundary.
        bus.we = 1'b1; bus.waddr = 5'd31; bus.wdata = 32'hCAFEF00D;
        next_cycle();
        bus.we = 1'b0; bus.raddr2 = 5'd31;
        settle();
        chk("r31", bus.rdata2, 32'hCAFEF00D);

`ifdef REGFILE_DEBUG_EN
        bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h00000077;
        bus.dbg_raddr = 5'd4; bus.raddr1 = 5'd4;
        settle();
        chk("dbg_no_bypass", bus.dbg_rdata, 32'h0);
        chk("rd1_bypass_r4", bus.rdata1, 32'h00000077);
        next_cycle();
        bus.we = 1'b0;
        settle();
        chk("dbg_commit", bus.dbg_rdata, 32'h00000077);
        bus.dbg_raddr = 5'd0;
        settle();
        chk("dbg_r0", bus.dbg_rdata, 32'h0);
        bus.dbg_raddr = 5'd4; rst = 1'b1;
        settle();
        chk("dbg_rst", bus.dbg_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file at the end of the pipeline.
- Write side takes the write-back triple (we, waddr, wdata) that leaves the memory stage via the MEM/WB register.
- Two read ports feed the decode stage.
- Synchronous write, combinational read, write-to-read bypass, register 0 hard-wired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width
NREG, 32, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
we  input  1  write enable from write-back
waddr  input  ADDR_W  write register index
wdata  input  DATA_W  write data
re1  input  1  read port 1 enable
raddr1  input  ADDR_W  read port 1 index
rdata1  output  DATA_W  read port 1 data
re2  input  1  read port 2 enable
raddr2  input  ADDR_W  read port 2 index
rdata2  output  DATA_W  read port 2 data

Behaviour:
- Storage: array reg[0..NREG-1] of DATA_W bits. reg[0] is never written and always reads 0.
- Reset: rst is synchronous, active-high.
  - At each rising edge with rst=1, all NREG entries clear to 0.
  - While rst=1, rdata1 and rdata2 are forced to 0 combinationally.
  - A write presented in the same cycle as rst is discarded.
- Write: at a rising edge with rst=0, we=1 and waddr!=0, reg[waddr] <= wdata.
  - we=1 with waddr=0 has no effect.
- Read, per port n, combinational, zero latency. Priority order:
  1. rst=1 -> 0
  2. ren=0 -> 0
  3. raddrn=0 -> 0
  4. we=1 and waddr==raddrn -> wdata (same-cycle bypass)
  5. otherwise reg[raddrn]
- Both ports may read the same index; both may hit the bypass simultaneously; each resolves independently.
- Reset mid-operation: any write in flight on the reset edge is lost. The first write after rst deasserts is accepted normally.
- No width conversion: all data paths are DATA_W; indices are used unsigned.
- No state machine. The sequential state is the register array only.

Optional Feature:
- Macro: REGFILE_DEBUG_EN
- Defined:
  - Adds ports dbg_raddr (input, ADDR_W) and dbg_rdata (output, DATA_W).
  - dbg_rdata is a third combinational read port with identical rules to the read ports, except it has no enable (always enabled).
  - It does NOT bypass: it shows committed array contents only, 0 for index 0 and 0 during rst.
  - Used by the top-level debug/trace harness.
- Undefined: ports absent; no extra logic.

Decomposition:
- Shared package: constants REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=0, and a typedef for the register index, reused by decode and the pipeline stages.
- One sub-module: regfile_read_port (combinational rules 1-5 above), instantiated twice. Instantiated a third time with bypass disabled when REGFILE_DEBUG_EN is defined.

Test Plan:
- Reset clear: preload reg5=0xDEADBEEF; hold rst 1 cycle; read raddr1=5, re1=1 -> rdata1=0. During rst, both rdata ports are 0 regardless of inputs.
- Basic write/read: write reg3=0x12345678; next cycle re1=1, raddr1=3 -> 0x12345678. With re1=0 -> 0.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF; then read raddr1=0 and raddr2=0 -> both 0, including in the same cycle as that write.
- Bypass: reg7=0x1; same cycle we=1, waddr=7, wdata=0xABCD, re1=re2=1, raddr1=raddr2=7 -> both ports 0xABCD combinationally; next cycle, with no write, -> 0xABCD from array.
- Write during reset: rst=1 with we=1, waddr=9, wdata=0x55; deassert rst; read reg9 -> 0.
- REGFILE_DEBUG_EN build: write reg4=0x77 in cycle N. In cycle N, dbg_raddr=4 -> old value 0 (no bypass); in cycle N+1 -> 0x77.
